// File: rtl/tdc_pulse_gen.sv
// Transmit side of the TDC pulse-count interface: start strobe, programmed pulse train,
// then waits for the counter's result and compares it with the programmed count.
`timescale 1ns/1ps

module tdc_pulse_gen #(
    parameter int WIDTH          = 8,
    parameter int HIGH_CYCLES    = 1,
    parameter int LOW_CYCLES     = 1,
    parameter int GAP_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] count_in,
    input  logic [WIDTH-1:0] count_back,
    input  logic             count_valid,
    output logic             tdc_start,
    output logic             tdc_data,
    output logic             busy,
    output logic             done,
    output logic             match,
    output logic             timeout
);

    localparam int MAX_HL  = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int MAX_HLG = (MAX_HL > GAP_CYCLES) ? MAX_HL : GAP_CYCLES;
    localparam int MAX_ALL = (MAX_HLG > TIMEOUT_CYCLES) ? MAX_HLG : TIMEOUT_CYCLES;
    localparam int TW      = $clog2(MAX_ALL + 1);

    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] HIGH_LAST = TW'(HIGH_CYCLES - 1);
    localparam logic [TW-1:0] LOW_LAST  = TW'(LOW_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, STRB, GAP, HIGH, LOW, WAIT, DONE} state_t;

    state_t           state, next_state;
    logic [TW-1:0]    timer;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] sent;
    logic             accept;
    logic             last_pulse;
    logic             tdc_start_d, tdc_data_d, busy_d, done_d;

    assign accept     = (state == IDLE) && start;
    // sent never exceeds count_q-1 here, so a full-scale count needs no extra bit
    assign last_pulse = (sent == count_q - WIDTH'(1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            tdc_start <= 1'b0;
            tdc_data  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= next_state;
            tdc_start <= tdc_start_d;
            tdc_data  <= tdc_data_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // NOTE: next_state gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (start) next_state = STRB;
            STRB: next_state = GAP;
            GAP:  if (timer == GAP_LAST) next_state = (count_q == '0) ? WAIT : HIGH;
            HIGH: if (timer == HIGH_LAST) next_state = LOW;
            LOW:  if (timer == LOW_LAST) next_state = last_pulse ? WAIT : HIGH;
            WAIT: if (count_valid || timer == TO_LAST) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from next_state and registered, so they line up with the state they describe.
    always_comb begin
        tdc_start_d = (next_state == STRB);
        tdc_data_d  = (next_state == HIGH);
        busy_d      = (next_state != IDLE);
        done_d      = (next_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            timer   <= '0;
            count_q <= '0;
            sent    <= '0;
            match   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if (next_state != state) begin
                timer <= '0;
            end else if (state inside {GAP, HIGH, LOW, WAIT}) begin
                timer <= timer + 1'b1;
            end

            if (accept) begin
                count_q <= count_in;
                sent    <= '0;
                match   <= 1'b0;
                timeout <= 1'b0;
            end else if (state == LOW && timer == LOW_LAST) begin
                sent <= sent + 1'b1;
            end

            // A valid result on the final timer cycle still counts as success
            if (state == WAIT) begin
                if (count_valid) begin
                    match   <= (count_back == count_q);
                    timeout <= 1'b0;
                end else if (timer == TO_LAST) begin
                    match   <= 1'b0;
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tdc_pulse_gen.sv
// Directed bench for tdc_pulse_gen with default parameters; expected values are hand-derived.
`timescale 1ns/1ps

module tb_tdc_pulse_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] count_in;
    logic [7:0] count_back;
    logic       count_valid;
    logic       tdc_start, tdc_data, busy, done, match, timeout;

    int passed = 0;
    int total  = 0;

    tdc_pulse_gen dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .count_in    (count_in),
        .count_back  (count_back),
        .count_valid (count_valid),
        .tdc_start   (tdc_start),
        .tdc_data    (tdc_data),
        .busy        (busy),
        .done        (done),
        .match       (match),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".tdc_start"}, 32'(tdc_start), 0);
        check({tag, ".tdc_data"},  32'(tdc_data),  0);
        check({tag, ".busy"},      32'(busy),      0);
        check({tag, ".done"},      32'(done),      0);
    endtask

    // One full burst. delay<0 means count_valid never arrives (timeout path).
    // noisy toggles start and alters count_in while busy, and asserts start in the DONE cycle.
    task automatic run_burst(input string tag, input int n, input logic [7:0] back,
                             input int delay, input bit noisy,
                             input bit exp_match, input bit exp_timeout);
        int   rises  = 0;
        int   highs  = 0;
        int   starts = 0;
        logic prev   = 1'b0;
        count_in = 8'(n);
        start    = 1'b1;
        tick();
        start = 1'b0;
        check({tag, ".strobe"},     32'(tdc_start), 1);
        check({tag, ".busy_rise"},  32'(busy),      1);
        check({tag, ".res_clear"},  32'({match, timeout}), 0);
        // GAP cycle followed by n HIGH/LOW pairs
        for (int c = 1; c <= 1 + 2 * n; c++) begin
            if (noisy) begin
                start    = c[0];
                count_in = 8'd7;
            end
            tick();
            if (tdc_data) highs++;
            if (tdc_data && !prev) rises++;
            prev   = tdc_data;
            starts += int'(tdc_start);
        end
        start = 1'b0;
        check({tag, ".rises"},  32'(rises),  32'(n));
        check({tag, ".highs"},  32'(highs),  32'(n));
        check({tag, ".starts"}, 32'(starts), 0);
        tick();
        check({tag, ".wait_busy"}, 32'(busy),     1);
        check({tag, ".wait_data"}, 32'(tdc_data), 0);
        check({tag, ".wait_done"}, 32'(done),     0);
        if (delay >= 0) begin
            for (int c = 0; c < delay; c++) tick();
            count_valid = 1'b1;
            count_back  = back;
            tick();
        end else begin
            for (int c = 0; c < 63; c++) tick();
            check({tag, ".no_done_63"}, 32'(done), 0);
            tick();
        end
        check({tag, ".done"},    32'(done),    1);
        check({tag, ".busy_d"},  32'(busy),    1);
        check({tag, ".match"},   32'(match),   32'(exp_match));
        check({tag, ".timeout"}, 32'(timeout), 32'(exp_timeout));
        count_valid = 1'b0;
        if (noisy) start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, ".idle_done"},  32'(done),    0);
        check({tag, ".idle_busy"},  32'(busy),    0);
        check({tag, ".hold_match"}, 32'(match),   32'(exp_match));
        check({tag, ".hold_to"},    32'(timeout), 32'(exp_timeout));
        tick();
        check({tag, ".no_restart"}, 32'({tdc_start, busy}), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst         = 1'b0;
        start       = 1'b0;
        count_in    = '0;
        count_back  = '0;
        count_valid = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset");
        check("reset.match",   32'(match),   0);
        check("reset.timeout", 32'(timeout), 0);
        rst = 1'b1;
        tick();
        check_idle_outputs("post_reset");

        // Basic run, result two cycles into WAIT
        run_burst("t1_n3", 3, 8'd3, 2, 1'b0, 1'b1, 1'b0);
        // Zero count: strobe only
        run_burst("t2_n0", 0, 8'd0, 0, 1'b0, 1'b1, 1'b0);
        // Full-scale count, no wrap
        run_burst("t3_n255", 255, 8'd255, 1, 1'b0, 1'b1, 1'b0);
        // Wrong echo
        run_burst("t3_bad", 3, 8'd4, 0, 1'b0, 1'b0, 1'b0);
        // No count_valid at all
        run_burst("t4_to", 2, 8'd0, -1, 1'b0, 1'b0, 1'b1);
        // Valid on the final timer cycle: success wins
        run_burst("t4_edge", 1, 8'd1, 63, 1'b0, 1'b1, 1'b0);

        // Reset during HIGH of pulse 2: STRB, GAP, HIGH, LOW, HIGH
        count_in = 8'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check("t5.in_high2", 32'(tdc_data), 1);
        rst = 1'b0;
        tick();
        check_idle_outputs("t5.abort");
        check("t5.abort_res", 32'({match, timeout}), 0);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("t5.no_done", 32'({done, busy}), 0);
        end
        run_burst("t5_after", 2, 8'd2, 0, 1'b0, 1'b1, 1'b0);

        // start while busy / in DONE and count_in changes are ignored
        run_burst("t6_noisy", 4, 8'd4, 1, 1'b1, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
